dcache_pmem_ram: RTL

Burst-capable responder for the data-cache pmem protocol, backed by an internal word-wide RAM with byte strobes. It sits at the slave end of the pmem port, behind the cache/uncached pmem mux, and serves as a tightly-coupled data memory and as the simulation memory model for cache line refills and writebacks. It accepts read bursts (one request, `len+1` data beats) and write bursts (`len+1` strobed beats, one final ack). It flags out-of-window accesses with `error`.

---
 rtl/dcache_pmem_ram.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/dcache_pmem_ram.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dcache_pmem_ram : burst pmem responder backed by a byte-strobed word RAM     |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
module dcache_pmem_ram #(
   parameter int          ADDR_W    = 12,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  inport_wr_i,
   input  logic        inport_rd_i,
   input  logic [7:0]  inport_len_i,
   input  logic [31:0] inport_addr_i,
   input  logic [31:0] inport_write_data_i,
   output logic        inport_accept_o,
   output logic        inport_ack_o,
   output logic        inport_error_o,
   output logic [31:0] inport_read_data_o
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [7:0]  len_q, len_d;
   logic [8:0]  cnt_q, cnt_d;
   logic        err_q, err_d;
   logic        ack_q, ack_d;
   logic        error_q, error_d;
   logic [31:0] rdata_q;

   logic [31:0] mem [0:(1<<ADDR_W)-1];

   logic [31:0]       w_beat_addr;
   logic              w_in_range;
   logic [ADDR_W-1:0] w_idx;
   logic              w_rd_issue;
   logic              w_wr_beat;
   logic              w_unused;

   // Beat 0 is addressed straight from the port; later beats from the counter.
   assign w_beat_addr = (state_q == ST_IDLE) ? inport_addr_i : addr_q;
   assign w_in_range  = (w_beat_addr[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);
   assign w_idx       = w_beat_addr[ADDR_W+1:2];
   assign w_unused    = ^w_beat_addr[1:0];

   assign inport_accept_o    = (state_q != ST_READ);
   assign inport_ack_o       = ack_q;
   assign inport_error_o     = error_q;
   assign inport_read_data_o = rdata_q;

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      len_d      = len_q;
      cnt_d      = cnt_q;
      err_d      = err_q;
      ack_d      = 1'b0;
      error_d    = 1'b0;
      w_rd_issue = 1'b0;
      w_wr_beat  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (|inport_wr_i) begin
               w_wr_beat = 1'b1;
               addr_d    = inport_addr_i + 32'd4;
               len_d     = inport_len_i;
               cnt_d     = 9'd1;
               err_d     = !w_in_range;
               if (inport_len_i == 8'd0) begin
                  ack_d   = 1'b1;
                  error_d = !w_in_range;
               end else begin
                  state_d = ST_WRITE;
               end
            end else if (inport_rd_i) begin
               w_rd_issue = 1'b1;
               ack_d      = 1'b1;
               error_d    = !w_in_range;
               addr_d     = inport_addr_i + 32'd4;
               len_d      = inport_len_i;
               cnt_d      = 9'd1;
               if (inport_len_i != 8'd0) begin
                  state_d = ST_READ;
               end
            end
         end
         ST_READ: begin
            // One extra cycle after the last issue keeps accept low through the final ack.
            if (cnt_q <= {1'b0, len_q}) begin
               w_rd_issue = 1'b1;
               ack_d      = 1'b1;
               error_d    = !w_in_range;
               addr_d     = addr_q + 32'd4;
               cnt_d      = cnt_q + 9'd1;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WRITE: begin
            if (|inport_wr_i) begin
               w_wr_beat = 1'b1;
               err_d     = err_q | !w_in_range;
               addr_d    = addr_q + 32'd4;
               cnt_d     = cnt_q + 9'd1;
               if (cnt_q == {1'b0, len_q}) begin
                  state_d = ST_IDLE;
                  ack_d   = 1'b1;
                  error_d = err_q | !w_in_range;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         len_q   <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         ack_q   <= 1'b0;
         error_q <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         ack_q   <= ack_d;
         error_q <= error_d;
         if (w_rd_issue) begin
            rdata_q <= w_in_range ? mem[w_idx] : 32'd0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr_beat && w_in_range) begin
         for (int b = 0; b < 4; b++) begin
            if (inport_wr_i[b]) begin
               mem[w_idx][b*8 +: 8] <= inport_write_data_i[b*8 +: 8];
            end
         end
      end
   end

endmodule
`default_nettype wire
